// File: rtl/grey_code6_check.sv
// grey_code6_check: synchronise a foreign 6-bit Gray counter, decode it, and check +1 steps with lock tracking
module grey_code6_check #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] grey_in,
  output logic [5:0] binary,
  output logic       advance,
  output logic       error,
  output logic       wrap,
  output logic       locked,
  output logic [7:0] err_count,
  output logic [7:0] wrap_count
);
  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;
  logic [5:0] r_sync [SYNC_STAGES];
  logic [5:0] r_prev;
  logic       r_primed;
  logic [3:0] r_good;
  state_t     r_state;
  logic [5:0] w_dec;
  logic [5:0] w_d;
  genvar i;
  for (i = 0; i < 6; i++) begin : g_dec
    assign w_dec[i] = ^r_sync[SYNC_STAGES-1][5:i];
  end
  assign w_d = w_dec - r_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= grey_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end
  // the first sample after reset only loads prev; pulses start on the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      binary   <= '0;
      r_prev   <= '0;
      r_primed <= 1'b0;
      advance  <= 1'b0;
      error    <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      binary   <= w_dec;
      r_prev   <= w_dec;
      r_primed <= 1'b1;
      advance  <= r_primed && w_d == 6'd1;
      error    <= r_primed && w_d > 6'd1;
      wrap     <= r_primed && w_d == 6'd1 && r_prev == 6'd63;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      err_count  <= err_count + 8'(error && err_count != 8'hff);
      wrap_count <= wrap_count + 8'(wrap);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= UNLOCKED;
      r_good  <= '0;
      locked  <= 1'b0;
    end else begin
      case (r_state)
        UNLOCKED: if (advance) begin
          r_good  <= 4'd1;
          r_state <= LOCK_N == 1 ? LOCKED : LOCKING;
          locked  <= LOCK_N == 1;
        end
        LOCKING: if (error) begin
          r_state <= UNLOCKED;
          r_good  <= '0;
        end else if (advance) begin
          r_good <= r_good + 4'd1;
          if (r_good + 4'd1 == 4'(LOCK_N)) begin
            r_state <= LOCKED;
            locked  <= 1'b1;
          end
        end
        LOCKED: if (error) begin
          r_state <= UNLOCKED;
          r_good  <= '0;
          locked  <= 1'b0;
        end
        default: r_state <= UNLOCKED;
      endcase
    end
  end
endmodule

// File: tb/tb_grey_code6_check.sv
// tb_grey_code6_check: directed Gray-code stimulus with a pulse scoreboard and direct counter/lock checks
module tb_grey_code6_check;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] grey_in = '0;
  logic [5:0] binary;
  logic       advance, error, wrap, locked;
  logic [7:0] err_count, wrap_count;
  typedef struct packed {logic a; logic e; logic w; logic [5:0] b;} ev_t;
  ev_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  grey_code6_check dut (
    .clk(clk), .rst(rst), .grey_in(grey_in), .binary(binary), .advance(advance),
    .error(error), .wrap(wrap), .locked(locked), .err_count(err_count), .wrap_count(wrap_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // expectation flags are supplied by the caller for each step
  task automatic drive(input int b, input int n, input logic a, input logic e, input logic w);
    int g;
    g = b ^ (b >> 1);
    grey_in = g[5:0];
    if (a || e) q.push_back({a, e, w, 6'(b)});
    tick(n);
  endtask
  task automatic do_reset(input int n);
    tick(4);
    chk("sb_drain_before_reset", q.size(), 0);
    rst = 1'b1;
    grey_in = '0;
    tick(n);
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (advance || error || wrap) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pulse: got adv=%0b err=%0b wrap=%0b bin=%0d want none", advance, error, wrap, binary);
      end else begin
        ev_t e;
        e = q.pop_front();
        n_chk++;
        if ({advance, error, wrap, binary} == e) n_pass++;
        else $display("FAIL pulse: got adv=%0b err=%0b wrap=%0b bin=%0d want adv=%0b err=%0b wrap=%0b bin=%0d",
                      advance, error, wrap, binary, e.a, e.e, e.w, e.b);
      end
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 3; k++) begin
      grey_in = 6'($urandom);
      tick(1);
    end
    rst = 1'b0;
    grey_in = '0;
    chk("rst_binary", binary, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_wrap_count", wrap_count, 0);
    chk("rst_locked", locked, 0);
    tick(4);
    chk("primed_no_pulse", {advance, error, wrap}, 0);
    for (int b = 1; b < 64; b++) begin
      if (b == 4) begin
        drive(4, 3, 1, 0, 0);
        chk("adv4_locked_low", locked, 0);
        tick(1);
        chk("adv4_locked_rise", locked, 1);
      end else drive(b, 2, 1, 0, 0);
    end
    drive(0, 2, 1, 0, 1);
    tick(3);
    chk("sweep_wrap_count", wrap_count, 1);
    chk("sweep_err_count", err_count, 0);
    chk("sweep_locked", locked, 1);
    chk("sweep_drain", q.size(), 0);
    for (int b = 1; b <= 10; b++) drive(b, 2, 1, 0, 0);
    tick(2);
    chk("at10_locked", locked, 1);
    drive(13, 4, 0, 1, 0);
    chk("jump_err_count", err_count, 1);
    chk("jump_locked", locked, 0);
    for (int b = 14; b <= 17; b++) drive(b, 2, 1, 0, 0);
    tick(2);
    chk("relock", locked, 1);
    for (int b = 18; b <= 20; b++) drive(b, 2, 1, 0, 0);
    drive(19, 4, 0, 1, 0);
    chk("back_err_count", err_count, 2);
    chk("back_locked", locked, 0);
    drive(20, 2, 1, 0, 0);
    drive(21, 2, 1, 0, 0);
    tick(5);
    chk("hold_no_pulse", {advance, error, wrap}, 0);
    drive(22, 4, 1, 0, 0);
    chk("hold_good3_unlocked", locked, 0);
    drive(23, 4, 1, 0, 0);
    chk("hold_good_kept_locked", locked, 1);
    do_reset(3);
    tick(3);
    for (int k = 1; k <= 300; k++) drive((k % 2) ? 32 : 0, 1, 0, 1, 0);
    tick(4);
    chk("sat_err_count", err_count, 255);
    for (int w = 0; w < 260; w++) begin
      for (int b = 1; b < 64; b++) drive(b, 1, 1, 0, 0);
      drive(0, 1, 1, 0, 1);
    end
    tick(4);
    chk("sat_err_hold", err_count, 255);
    chk("wrap_count_mod", wrap_count, 4);
    chk("wraps_locked", locked, 1);
    do_reset(1);
    tick(3);
    for (int k = 1; k <= 7; k++) drive((k % 2) ? 32 : 0, 2, 0, 1, 0);
    for (int b = 33; b <= 36; b++) drive(b, 2, 1, 0, 0);
    tick(3);
    chk("pre_rst_err_count", err_count, 7);
    chk("pre_rst_locked", locked, 1);
    chk("pre_rst_drain", q.size(), 0);
    rst = 1'b1;
    grey_in = '0;
    tick(1);
    rst = 1'b0;
    chk("midrst_outputs", {binary, advance, error, wrap, locked, err_count, wrap_count}, 0);
    tick(1);
    drive(1, 4, 1, 0, 0);
    chk("midrst_binary", binary, 1);
    tick(3);
    chk("final_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/grey_code6_check.md
# grey_code6_check

Receiving end for the free-running 6-bit Gray-code counters in the clock-scaling test block. It synchronises a Gray-code bus from a foreign counter into its own clock domain, decodes each sample to binary, and checks that consecutive samples differ by a legal single-step increment. It reports progress, errors, wraps and a lock status so the scaled clocks can be verified on-chip.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on `grey_in`; legal range 2..4.
- `LOCK_N`, default 4: consecutive good advances needed to declare lock; legal range 1..15.
- `clk` in 1: sampling clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `grey_in` in 6: Gray code from a counter in any clock domain; treated as asynchronous.
- `binary` out 6: binary decode of the current synchronised sample.
- `advance` out 1: one-cycle pulse; the sample advanced by exactly +1 mod 64.
- `error` out 1: one-cycle pulse; illegal transition detected.
- `wrap` out 1: one-cycle pulse; the transition was 63 -> 0 in binary.
- `locked` out 1: lock state machine is in LOCKED.
- `err_count` out 8: number of errors; saturates at 255.
- `wrap_count` out 8: number of wraps; rolls over mod 256.

## Operation
- **Synchroniser.** A chain of `SYNC_STAGES` flops on `grey_in` produces `g_sync`. No logic sits between the stages.
- **Decode.** `b[5] = g[5]`, and `b[i] = b[i+1] ^ g[i]`. The result is registered into `binary`. The previous binary value is held in `prev`.
- **Priming.** A `primed` flag is clear after reset.
  - The first decoded sample loads `prev` and sets `primed`.
  - No pulse is generated for that sample.
- **Per-cycle check** once `primed` is set, using `d = binary_new - prev` mod 64:
  - `d == 0`: hold. No pulse.
  - `d == 1`: `advance` pulses. If `prev == 63`, `wrap` also pulses and `wrap_count` increments.
  - Any other `d`, including 63 (backwards): `error` pulses and `err_count` increments, saturating at 255.
  - A multi-bit Gray change at the input decodes to some `d` other than 0 or 1, so it is flagged through the same rule.
- `prev` is updated with the new sample every cycle, whether or not the transition was legal.
- `advance` and `error` are mutually exclusive. `wrap` is only ever asserted together with `advance`.
- **Lock state machine** uses a 4-bit counter `good`.
  - **UNLOCKED** (reset state): `good = 0`.
    - First `advance` -> LOCKING with `good = 1`.
    - If `LOCK_N == 1`, go directly to LOCKED.
  - **LOCKING**:
    - `advance` -> `good + 1`; when `good` reaches `LOCK_N`, go to LOCKED.
    - hold -> stay; `good` is unchanged.
    - `error` -> UNLOCKED with `good = 0`.
  - **LOCKED**: `locked = 1`.
    - `error` -> UNLOCKED.
    - hold or `advance` -> stay.
- Reset values: every output is 0. The synchroniser flops, `prev`, `primed`, `good` and both counters are 0, and the state is UNLOCKED.

## Timing
- **Input latency.** A `grey_in` value stable before edge N reaches `g_sync` at edge N+`SYNC_STAGES`-1. It appears on `binary` at edge N+`SYNC_STAGES`, which is edge N+2 with the default depth.
- **Pulse timing.** `advance`, `error` and `wrap` are registered. Each is asserted in the same cycle that `binary` shows the new value, and lasts exactly 1 cycle per transition.
- **Counters and lock.**
  - `err_count` and `wrap_count` update one cycle after their pulse, i.e. registered from the same condition.
  - `locked` rises in the cycle after the `LOCK_N`-th advance pulse.
- **Reset.**
  - When `rst` is sampled high at edge N, all state is at its reset value after edge N, including mid-operation. There is no partial flush.
  - After release, the first sample that reaches `binary` only primes the checker and never pulses.
- **Source rate.** The source counter must step no faster than once per two `clk` periods for error-free operation. Faster sources are legitimately reported as errors.

## Test plan
- **Reset values.** Hold `rst` for 3 cycles with random `grey_in`. Then `binary = 0`, `err_count = 0`, `wrap_count = 0` and `locked = 0`, and no pulse occurs in the first primed cycle.
- **Slow sweep.** Drive Gray codes 0..63..0, each held for 2 cycles. Expected:
  - 64 `advance` pulses and exactly 1 `wrap`, at binary 63 -> 0.
  - `wrap_count = 1` and `err_count = 0`.
  - `locked` asserts 1 cycle after the 4th advance pulse.
- **Lock loss.** With the checker locked at binary 10, jump `grey_in` to Gray(13). Then exactly 1 `error` pulse occurs, `err_count` increments by 1 and `locked` drops.
  - Four further +1 steps restore `locked`.
- **Backward step.** Step binary 20 -> 19. The result is an `error` pulse with no `advance` pulse.
  - A following hold of 5 cycles produces no pulses and leaves `good` unchanged.
- **Saturation and wrap counters.** Force 300 illegal jumps, then run 260 wraps. Then `err_count = 255` and `wrap_count = 4`.
- **Mid-run reset.** Pulse `rst` for 1 cycle while the checker is locked with `err_count = 7`.
  - All outputs return to 0 on the next cycle.
  - The next sample only primes the checker; the sample after it pulses `advance`.
